// File: rtl/pwm_pkg.sv
// Shared defaults, helper and detector state type for the PWM capture path.
package pwm_pkg;

  localparam int FRAME_BITS_DEF  = 8;
  localparam int PERIOD_BITS_DEF = 12;
  localparam int HYST_DEF        = 8;

  typedef enum logic {
    DET_LOW  = 1'b0,
    DET_HIGH = 1'b1
  } det_state_t;

  // Mid-scale duty value for a frame of 2^frame_bits clocks.
  function automatic int midpoint(input int frame_bits);
    return 1 << (frame_bits - 1);
  endfunction

endpackage

// File: rtl/pwm_tone_detect.sv
// Hysteresis crossing detector on recovered frame samples.
// Reports frames between consecutive rising crossings, plus a silence flag
// once the frame counter saturates without a crossing.
//
// state    | meaning
// DET_LOW  | last accepted level below midpoint - HYST
// DET_HIGH | last accepted level at or above midpoint + HYST
module pwm_tone_detect
  import pwm_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int HYST        = HYST_DEF,
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_done,
  input  logic [FRAME_BITS-1:0]  result,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   period_valid,
  output logic                   silent
);

  localparam int MID = midpoint(FRAME_BITS);
  localparam logic [FRAME_BITS:0]    HI_TH     = (FRAME_BITS+1)'(MID + HYST);
  localparam logic [FRAME_BITS:0]    LO_TH     = (FRAME_BITS+1)'(MID - HYST);
  localparam logic [PERIOD_BITS-1:0] FCNT_MAX  = '1;
  localparam logic [PERIOD_BITS-1:0] FCNT_ONE  = PERIOD_BITS'(1);

  det_state_t             state;
  logic                   armed;
  logic [PERIOD_BITS-1:0] fcnt;
  logic [FRAME_BITS:0]    res_ext;
  logic                   rise;
  logic                   fall;

  assign res_ext = {1'b0, result};
  assign rise    = (state == DET_LOW)  && (res_ext >= HI_TH);
  assign fall    = (state == DET_HIGH) && (res_ext <  LO_TH);

  // Detector FSM, frame counter and registered period/silence outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DET_LOW;
      armed        <= 1'b0;
      fcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      if (frame_done) begin
        if (rise) begin
          state <= DET_HIGH;
          fcnt  <= '0;
          if (armed) begin
            period       <= fcnt + FCNT_ONE;
            period_valid <= 1'b1;
            silent       <= 1'b0;
          end else begin
            armed <= 1'b1;
          end
        end else begin
          if (fall) state <= DET_LOW;
          if (fcnt != FCNT_MAX) begin
            fcnt <= fcnt + FCNT_ONE;
            // Timeout: the next count is terminal, so the tone is gone and
            // the next rising crossing only re-arms.
            if (fcnt == FCNT_MAX - FCNT_ONE) begin
              silent <= 1'b1;
              armed  <= 1'b0;
              period <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_demod.sv
// PWM stream demodulator: synchronizes pwm_in, counts high clocks per frame,
// offers each frame result on a valid/ready port and feeds the tone detector.
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int HYST        = HYST_DEF,
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pwm_in,
  input  logic                   enable,
  output logic [FRAME_BITS-1:0]  sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   period_valid,
  output logic                   silent
);

  localparam logic [FRAME_BITS-1:0] CNT_MAX = '1;

  logic                  sync_1;
  logic                  pwm_s;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic [FRAME_BITS-1:0] high_acc;
  logic                  frame_done;
  logic [FRAME_BITS:0]   sum;
  logic [FRAME_BITS-1:0] result;

  assign frame_done = enable && (frame_cnt == CNT_MAX);
  // A frame that is high on every clock counts 2^FRAME_BITS, which does not
  // fit the sample width; clamp it to full scale.
  assign sum    = {1'b0, high_acc} + {{FRAME_BITS{1'b0}}, pwm_s};
  assign result = sum[FRAME_BITS] ? CNT_MAX : sum[FRAME_BITS-1:0];

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      pwm_s  <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      pwm_s  <= sync_1;
    end
  end

  // Frame position and high-cycle accumulation; disable restarts the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      high_acc  <= '0;
    end else if (!enable || frame_done) begin
      frame_cnt <= '0;
      high_acc  <= '0;
    end else begin
      frame_cnt <= frame_cnt + FRAME_BITS'(1);
      high_acc  <= high_acc + {{(FRAME_BITS-1){1'b0}}, pwm_s};
    end
  end

  // Output register with valid/ready handshake; a full register drops results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (frame_done && (!sample_valid || sample_ready)) begin
      sample       <= result;
      sample_valid <= 1'b1;
    end else if (!frame_done && sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (frame_done && sample_valid && !sample_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  pwm_tone_detect #(
    .FRAME_BITS  (FRAME_BITS),
    .HYST        (HYST),
    .PERIOD_BITS (PERIOD_BITS)
  ) u_tone (
    .clk          (clk),
    .rst          (rst),
    .frame_done   (frame_done),
    .result       (result),
    .period       (period),
    .period_valid (period_valid),
    .silent       (silent)
  );

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod. The period counter is narrowed to 6 bits so
// the silence timeout (63 frames) fits a short run; frame length stays 256.
// Stimulus frames are aligned with the DUT frame counter. Because of the
// 2-clock synchronizer, a frame captures the last two input clocks of the
// previous stimulus frame, so a frame whose predecessor ends low captures
// exactly its own duty (up to 254).
module tb_pwm_demod;
  localparam int FB = 8;
  localparam int HY = 8;
  localparam int PB = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic          enable = 1'b1;
  logic          sample_ready = 1'b1;
  logic          overrun_clr = 1'b0;
  logic [FB-1:0] sample;
  logic          sample_valid;
  logic          overrun;
  logic [PB-1:0] period;
  logic          period_valid;
  logic          silent;

  int total = 0;
  int bad   = 0;
  int pv_cnt = 0;
  int sv_cnt = 0;
  int ovr_mid = 0;
  int n;

  always #5 clk = ~clk;

  pwm_demod #(.FRAME_BITS(FB), .HYST(HY), .PERIOD_BITS(PB)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .period       (period),
    .period_valid (period_valid),
    .silent       (silent)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive pwm_in for this cycle, then sample #1 after the edge.
  task automatic step(input logic p);
    pwm_in = p;
    @(posedge clk);
    #1;
    if (period_valid) pv_cnt++;
    if (sample_valid) sv_cnt++;
  endtask

  // One aligned frame; high for the first 'duty' clocks. overrun_clr can be
  // pulsed on the first and/or the frame_done cycle.
  task automatic run_frame(input int duty, input bit clr_first, input bit clr_last);
    for (int k = 0; k < 256; k++) begin
      overrun_clr = (k == 0 && clr_first) || (k == 255 && clr_last);
      if (k == 128) ovr_mid = overrun;
      step(k < duty);
    end
    overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    overrun_clr = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pv_cnt = 0;
    sv_cnt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sample"}, sample, 0);
    check_val({tag, "_valid"}, sample_valid, 0);
    check_val({tag, "_overrun"}, overrun, 0);
    check_val({tag, "_period"}, period, 0);
    check_val({tag, "_pvalid"}, period_valid, 0);
    check_val({tag, "_silent"}, silent, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int duty;
    #12;
    check_reset_vals("rst");

    // Zero input: first result one clock after the 256th frame clock.
    do_reset();
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (!sample_valid && n < 300);
    check_val("first_valid_lat", n, 256);
    check_val("zero_sample0", sample, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(0, 0, 0);
      check_val("zero_sample", sample, 0);
      check_val("zero_valid", sample_valid, 1);
    end
    check_val("zero_sv_cnt", sv_cnt, 3);
    check_val("zero_silent", silent, 1);

    // Constant high saturates at 255 once the synchronizer is full.
    do_reset();
    run_frame(256, 0, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(256, 0, 0);
      check_val("ones_sample", sample, 255);
    end
    check_val("ones_no_pvalid", pv_cnt, 0);

    // Steady duties 64 then 128.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(64, 0, 0);
      check_val("duty64", sample, 64);
    end
    for (int f = 0; f < 2; f++) begin
      run_frame(128, 0, 0);
      check_val("duty128", sample, 128);
    end

    // Overrun: 100 is taken, later frames dropped while not ready.
    run_frame(100, 0, 0);
    check_val("ovr_a_sample", sample, 100);
    check_val("ovr_a_flag", overrun, 0);
    sample_ready = 1'b0;
    run_frame(30, 0, 0);
    check_val("ovr_b_sample", sample, 100);
    check_val("ovr_b_valid", sample_valid, 1);
    check_val("ovr_b_flag", overrun, 1);
    run_frame(30, 1, 1);
    check_val("ovr_clr_mid", ovr_mid, 0);
    check_val("ovr_setwins", overrun, 1);
    check_val("ovr_c_sample", sample, 100);
    sample_ready = 1'b1;
    run_frame(30, 1, 0);
    check_val("ovr_e_mid", ovr_mid, 0);
    check_val("ovr_e_sample", sample, 30);
    check_val("ovr_e_flag", overrun, 0);

    // Tone: 200 x5 / 50 x5, period 10 from the second rising crossing.
    do_reset();
    for (int f = 0; f < 30; f++) begin
      duty = (f % 10 < 5) ? 200 : 50;
      run_frame(duty, 0, 0);
      check_val("tone_sample", sample, duty);
      check_val("tone_pvalid", period_valid, (f == 10 || f == 20) ? 1 : 0);
      check_val("tone_silent", silent, (f < 10) ? 1 : 0);
      if (f == 10 || f == 20) check_val("tone_period", period, 10);
    end
    check_val("tone_pv_cnt", pv_cnt, 2);
    // Last rise at frame 20; counter reaches 63 on frame 83.
    for (int f = 30; f < 84; f++) begin
      run_frame(128, 0, 0);
      if (f == 82) begin
        check_val("pre_timeout_silent", silent, 0);
        check_val("pre_timeout_period", period, 10);
      end
    end
    check_val("timeout_silent", silent, 1);
    check_val("timeout_period", period, 0);
    check_val("timeout_pv_cnt", pv_cnt, 2);

    // Reset mid-frame with a held sample and an active tone.
    do_reset();
    sample_ready = 1'b0;
    for (int f = 0; f < 11; f++) begin
      run_frame((f % 10 < 5) ? 200 : 50, 0, 0);
    end
    for (int k = 0; k < 100; k++) step(1'b1);
    check_val("pre_rst_valid", sample_valid, 1);
    check_val("pre_rst_silent", silent, 0);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    sample_ready = 1'b1;

    // Enable dropped mid-frame: that frame is lost, next full frame counts.
    do_reset();
    run_frame(64, 0, 0);
    check_val("en_sample0", sample, 64);
    sv_cnt = 0;
    for (int k = 0; k < 100; k++) step(k < 64);
    enable = 1'b0;
    for (int k = 0; k < 300; k++) step(1'b0);
    check_val("en_off_sv_cnt", sv_cnt, 0);
    check_val("en_off_sample", sample, 64);
    enable = 1'b1;
    run_frame(80, 0, 0);
    check_val("en_on_sample", sample, 80);
    check_val("en_on_valid", sample_valid, 1);
    check_val("en_on_sv_cnt", sv_cnt, 1);
    check_val("en_on_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
